fft_sequencer: RTL
==================

// Module: fft_sequencer
// PURPOSE
// - Top-level initiator for the fft_stage_control en/stage_num/stage_done handshake.
// - Sequences one FFT frame through three phases:
//   - load N samples from the input stream,
//   - run stages 0..NUMSTAGES-1 back to back,
//   - unload N results in bit-reversed order.
// - Sits between the sample interface and fft_stage_control; owns the sample-memory load/unload addresses.
// PARAMETERS
// - NUMSTAGES  5   FFT stages; N = 2**NUMSTAGES points (32).
// - TIMEOUT    64  max cycles per stage before error; used only with STAGE_TIMEOUT_EN.
// PORTS
// - clk          in   1            clock, all state on rising edge
// - rst_n        in   1            async active-low reset
// - start        in   1            begin a frame; sampled only in IDLE
// - in_valid     in   1            input sample valid
// - in_ready     out  1            sequencer accepts a sample (LOAD state)
// - load_addr    out  NUMSTAGES    memory write address for the current sample
// - load_we      out  1            in_valid & in_ready
// - stage_en     out  1            drives fft_stage_control en
// - stage_num    out  3            drives fft_stage_control stage_num
// - stage_done   in   1            from fft_stage_control
// - out_valid    out  1            result address valid (UNLOAD state)
// - out_ready    in   1            downstream accepts the result
// - unload_addr  out  NUMSTAGES    bit-reverse of unload count; memory read is zero-latency
// - busy         out  1            state != IDLE
// - fft_done     out  1            one-cycle pulse after the last unload handshake
// - err          out  1            sticky stage timeout flag (STAGE_TIMEOUT_EN only, else 0)
// BEHAVIOUR
// - Reset: rst_n=0 asynchronously forces IDLE.
//   - All outputs 0; counters 0; stage_num=0; err=0.
//   - Applies mid-frame too; the frame is abandoned and no fft_done is issued.
// - States: IDLE, LOAD, RUN, GAP, UNLOAD (+ ERROR with macro).
// - IDLE:
//   - start=1 -> LOAD next edge, count=0.
//   - start in any other state is ignored.
// - LOAD:
//   - in_ready=1, load_addr=count.
//   - Each in_valid&in_ready increments count.
//   - Handshake at count=N-1 -> RUN, count=0, stage_num=0.
// - RUN:
//   - stage_en=1.
//   - stage_done=1 -> GAP next edge.
// - GAP (exactly one cycle):
//   - stage_en=0; stage_done is ignored, since fft_stage_control clears it on this edge.
//   - If stage_num == NUMSTAGES-1 -> UNLOAD, stage_num=0.
//   - Otherwise stage_num+1 -> RUN.
//   - stage_num changes only on leaving GAP, never while stage_en=1.
// - UNLOAD:
//   - out_valid=1, unload_addr=bitrev(count).
//   - Each out_valid&out_ready increments count.
//   - Handshake at count=N-1 -> IDLE, fft_done=1 for one cycle, count=0.
// - Stall: out_valid and unload_addr hold while out_ready=0; in_ready stays high while in_valid=0.
// - Count width is NUMSTAGES and wraps naturally only at the phase end.
// - stage_num is a 3-bit register; NUMSTAGES must be <= 8.
// - busy=1 from the edge leaving IDLE until the edge returning to IDLE.
// CONFIGURATION
// - STAGE_TIMEOUT_EN defined:
//   - A watchdog counts RUN cycles and resets on entry to RUN.
//   - Reaching TIMEOUT without stage_done -> ERROR: stage_en=0, err=1, busy=1.
//   - ERROR is left only by rst_n.
// - STAGE_TIMEOUT_EN undefined:
//   - No watchdog; RUN waits indefinitely; err tied 0.
// TESTING
// - Reset and start:
//   - Stimulus: release rst_n, pulse start, drive 32 samples with in_valid=1 continuously.
//   - Required: load_addr 0..31, one sample per cycle.
//   - Required: RUN begins the cycle after the 32nd handshake with stage_en=1, stage_num=0.
// - Stage stepping with a real fft_stage_control:
//   - Required: each stage lasts 9 cycles of en=1 followed by 1 GAP cycle.
//   - Required: stage_num steps 0,1,2,3,4, then UNLOAD starts.
// - Bit-reversed unload:
//   - Stimulus: out_ready=1.
//   - Required: unload_addr sequence 0,16,8,24,4,... ending at 31.
//   - Required: fft_done pulses exactly once; busy drops on the same edge.
// - Backpressure:
//   - Stimulus: toggle out_ready 1,0,0,1 and gap in_valid.
//   - Required: addresses hold, no skipped or duplicated indices, counts stay 32.
// - Reset mid-RUN:
//   - Stimulus: assert rst_n=0 at stage 2.
//   - Required: all outputs 0 immediately, state IDLE, no fft_done.
//   - Required: start is ignored while busy.
// - With STAGE_TIMEOUT_EN:
//   - Stimulus: hold stage_done=0.
//   - Required: err=1 and stage_en=0 after 64 RUN cycles; recovery only via rst_n.

Source files
------------

// File: rtl/fft_sequencer.sv
// fft_sequencer: top-level initiator for one FFT frame.
// Loads N = 2**NUMSTAGES samples and runs stages 0..NUMSTAGES-1 through the
// fft_stage_control en/stage_num/stage_done handshake. It then unloads the
// results in bit-reversed address order.
// Optional feature macro: STAGE_TIMEOUT_EN. It adds a per-stage watchdog and
// a sticky ERROR state, and drives err.
module fft_sequencer #(
  parameter int NUMSTAGES = 5,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [NUMSTAGES-1:0] load_addr,
  output logic                 load_we,
  output logic                 stage_en,
  output logic [2:0]           stage_num,
  input  logic                 stage_done,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUMSTAGES-1:0] unload_addr,
  output logic                 busy,
  output logic                 fft_done,
  output logic                 err
);

  localparam logic [NUMSTAGES-1:0] LAST_COUNT = '1;
  localparam logic [2:0]           LAST_STAGE = 3'(NUMSTAGES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    GAP,
    UNLOAD
`ifdef STAGE_TIMEOUT_EN
    , ERROR
`endif
  } state_t;

  state_t                 state, state_next;
  logic [NUMSTAGES-1:0]   count, count_next;
  logic [2:0]             stage_q, stage_next;
  logic                   done_q, done_next;

  // Illegal parameter values (stage_num is only 3 bits wide) leave this marker scope in the hierarchy
  if (NUMSTAGES < 1 || NUMSTAGES > 8 || TIMEOUT < 1) begin : g_bad_params
  end

`ifdef STAGE_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;

  // Watchdog counts consecutive RUN cycles; it is held at zero elsewhere so every stage starts fresh
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (state == RUN) begin
      wd_cnt <= wd_cnt + 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end
`endif

  // State, shared load/unload counter, stage number and done-pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      stage_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      stage_q <= stage_next;
      done_q  <= done_next;
    end
  end

  // Next-state logic; the counter wraps to zero by itself on the last handshake of a phase
  always_comb begin
    state_next = state;
    count_next = count;
    stage_next = stage_q;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
          count_next = '0;
        end
      end
      LOAD: begin
        if (in_valid) begin
          count_next = count + 1'b1;
          if (count == LAST_COUNT) begin
            state_next = RUN;
            stage_next = '0;
          end
        end
      end
      RUN: begin
        if (stage_done) begin
          state_next = GAP;
        end
`ifdef STAGE_TIMEOUT_EN
        else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
          state_next = ERROR;
        end
`endif
      end
      GAP: begin
        if (stage_q == LAST_STAGE) begin
          state_next = UNLOAD;
          stage_next = '0;
        end else begin
          state_next = RUN;
          stage_next = stage_q + 3'd1;
        end
      end
      UNLOAD: begin
        if (out_ready) begin
          count_next = count + 1'b1;
          if (count == LAST_COUNT) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
`ifdef STAGE_TIMEOUT_EN
      ERROR: begin
        state_next = ERROR;
      end
`endif
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Unload reads memory at the bit-reversed count so results leave in natural order
  always_comb begin
    unload_addr = '0;
    for (int i = 0; i < NUMSTAGES; i++) begin
      unload_addr[i] = count[NUMSTAGES-1-i];
    end
  end

  assign in_ready  = (state == LOAD);
  assign load_addr = count;
  assign load_we   = in_valid & in_ready;
  assign stage_en  = (state == RUN);
  assign stage_num = stage_q;
  assign out_valid = (state == UNLOAD);
  assign busy      = (state != IDLE);
  assign fft_done  = done_q;

`ifdef STAGE_TIMEOUT_EN
  assign err = (state == ERROR);
`else
  assign err = 1'b0;
`endif

endmodule
